// File: rtl/sync_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_ctrl
// Brief    : Push/pop FIFO controller driving one read-before-write
//            dual_port_ram. Define FIFO_ERR_EN to add sticky overflow and
//            underflow flags.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  we_enb,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] data_in,
    output logic                  re_enb,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_data_out
`ifdef FIFO_ERR_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int c_PTR_W = ADDR_WIDTH + 1;

    logic [c_PTR_W-1:0] wptr_q, wptr_d;
    logic [c_PTR_W-1:0] rptr_q, rptr_d;
    logic [c_PTR_W-1:0] count_q, count_d;
    logic               dout_valid_q, dout_valid_d;
    logic               w_full, w_empty;
    logic               w_push_ok, w_pop_ok;

    // Flags come only from registered pointers; the extra MSB tells a full lap from none.
    assign w_empty = (wptr_q == rptr_q);
    assign w_full  = (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]) &&
                     (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]);

    // A pop frees a slot on the same edge, so a push at full is allowed alongside it.
    assign w_pop_ok  = pop & ~w_empty;
    assign w_push_ok = push & (~w_full | w_pop_ok);

    always_comb begin
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        count_d      = count_q;
        dout_valid_d = w_pop_ok;
        if (w_push_ok) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (w_pop_ok) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({w_push_ok, w_pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            dout_valid_q <= dout_valid_d;
        end
    end

`ifdef FIFO_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q  | (push & ~w_push_ok);
        underflow_d = underflow_q | (pop  & ~w_pop_ok);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

    assign we_enb     = w_push_ok;
    assign wr_addr    = wptr_q[ADDR_WIDTH-1:0];
    assign data_in    = din;
    assign re_enb     = w_pop_ok;
    assign rd_addr    = rptr_q[ADDR_WIDTH-1:0];
    assign dout       = ram_data_out;
    assign dout_valid = dout_valid_q;
    assign full       = w_full;
    assign empty      = w_empty;
    assign count      = count_q;

endmodule
`default_nettype wire
